mmio_console: RTL and testbench
===============================

# mmio_console

Memory-mapped console and simulation-control peripheral on the RS5 data bus, in the 0x8000_0000 region (`mem_address[31:28] >= 4'h8`). It accepts character writes from the core into a small FIFO and drains them byte-by-byte over a valid/ready stream to a host-side sink such as a file writer or UART model. It also exposes status, control and end-of-simulation registers with registered read data, and raises a low-watermark interrupt.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `GAP`, 0: minimum idle cycles between two consecutive pops; 0 allows back-to-back pops.
- `LOW_WM`, 2: the interrupt asserts while occupancy is below this value.
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en_i`  in  1  bus select for this block; held for one cycle per access.
- `we_i`  in  4  byte write enables; `4'h0` means a read.
- `addr_i`  in  16  offset, driven from `mem_address[15:0]`.
- `data_i`  in  32  write data.
- `data_o`  out  32  registered read data.
- `tx_data_o`  out  8  byte at the FIFO head.
- `tx_valid_o`  out  1  `tx_data_o` is valid.
- `tx_ready_i`  in  1  the sink accepts the byte.
- `end_o`  out  1  sticky end-of-simulation flag.
- `exit_code_o`  out  8  exit code latched by the first END write.
- `irq_o`  out  1  level interrupt.

## Operation
- **Register map.** Decode uses the full `addr_i`.
  - `0x0000` END (write only).
  - `0x1000` and `0x4000` TXDATA (write only, aliases).
  - `0x2000` STATUS.
  - `0x3000` CTRL.
  - Any other offset: writes are ignored and reads return 0.
- **TXDATA write** (`en_i` high, `we_i[0]` high):
  - Pushes `data_i[7:0]`.
  - If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and `overflow` is set (sticky).
  - A write with `we_i[0]` low but other enable bits set is ignored.
- **STATUS read layout:**
  - bit 0: `empty`
  - bit 1: `full`
  - bit 2: `overflow`
  - bit 3: `end_o`
  - bits [15:8]: occupancy count
  - all other bits: 0
- **STATUS write** with `we_i[0]` high and `data_i[2]` equal to 1 clears `overflow`. All other bits are read-only.
- **CTRL:**
  - bit 0 `ie`, read/write through `we_i[0]`.
  - Other bits read 0.
- **END write** (any `we_i` bit set):
  - If `end_o` is 0: set `end_o` and latch `exit_code_o <= data_i[7:0]`.
  - Later END writes are ignored; the first write wins.
  - TXDATA writes and draining continue after `end_o` is set.
- **Drain:**
  - The FIFO is first-word-fall-through; `tx_data_o` is the head entry.
  - A gap counter `gcnt` is loaded with `GAP` on every pop and decrements to 0.
  - `tx_valid_o = !empty && gcnt == 0`.
  - Pop occurs when `tx_valid_o && tx_ready_i`.
  - Once `tx_valid_o` is high, it stays high and `tx_data_o` stays stable until the byte is accepted.
- **Occupancy and pointers:**
  - Occupancy range is 0..DEPTH, held in a `$clog2(DEPTH)+1`-bit counter.
  - Pointers wrap modulo `DEPTH`.
- **Push on full:** a push is accepted when `count < DEPTH`, or when `count == DEPTH` and a pop occurs in the same cycle. In that case the count stays at `DEPTH`.
- **Push on empty:** a push into an empty FIFO is not visible on `tx_valid_o` until the next cycle. The count increments by 1.
- **Interrupt:** `irq_o` is registered, `irq_o <= ie && (count_next < LOW_WM)`.

## Timing
- **Read latency:**
  - `data_o` updates on the edge after a read (`en_i` high, `we_i == 0`), matching the one-cycle registered select in the bus mux.
  - On cycles without a read, `data_o <= 0`.
  - A read in the same cycle as a push returns the pre-push STATUS.
- **Write visibility:**
  - Write effects are visible one cycle after the write cycle.
  - A push at cycle t gives `tx_valid_o` high at t+1 at the earliest.
- **Throughput:**
  - With `GAP = 0` and `tx_ready_i` held high, one pop per cycle.
  - With `GAP = N`, consecutive pops occur at least N+1 cycles apart.
- **Reset values:**
  - FIFO empty, `count` = 0, pointers = 0.
  - `gcnt` = 0, `overflow` = 0, `ie` = 0.
  - `data_o` = 0, `tx_valid_o` = 0, `tx_data_o` = 0.
  - `end_o` = 0, `exit_code_o` = 0, `irq_o` = 0.
- **Reset mid-operation:** reset discards queued bytes and drops `tx_valid_o` on the next edge, even if a handshake is pending.
- **No combinational paths:** none from `tx_ready_i` to `data_o` or `irq_o`. `tx_valid_o` depends only on registered state.

## Test plan
- **Single byte:** with `GAP = 0` and `tx_ready_i = 1`, write `0x41` to `0x4000` at cycle t.
  - Expect `tx_valid_o` high with `tx_data_o = 0x41` at t+1.
  - Expect the FIFO empty at t+2.
  - Expect STATUS to read `0x00000001`.
- **Overflow:** with `tx_ready_i = 0`, write 17 bytes `0x00..0x10` to `0x1000`.
  - Expect STATUS `= 0x00001006` (count 16, full, overflow).
  - Then drain: the sink receives `0x00..0x0F` in order, and `0x10` is lost.
  - Then write `0x4` to STATUS: `overflow` clears.
- **Push and pop on full:** fill 16 bytes, then push `0xAA` in the same cycle as a pop.
  - The count stays at 16.
  - `0xAA` comes out last, and `overflow` remains 0.
- **Pacing:** with `GAP = 3`, `tx_ready_i = 1`, push 4 bytes back-to-back.
  - Pops occur exactly 4 cycles apart.
  - Dropping `tx_ready_i` while valid holds `tx_data_o` stable.
- **Interrupt:** write CTRL `= 1` with the FIFO empty; expect `irq_o` high the next cycle.
  - Push 2 bytes with `tx_ready_i = 0`: `irq_o` falls.
  - Drain one byte: `irq_o` rises again.
- **End and reset:**
  - Write END with `0x05`, then END with `0x07`: `end_o = 1` and `exit_code_o = 0x05`.
  - Assert `reset` for one cycle with 3 bytes queued: all outputs return to 0 on the next edge.

Source files
------------

// File: rtl/mmio_console.sv
`default_nettype none
// ============================================================================
// Module      : mmio_console
// Description : Memory-mapped console FIFO with valid/ready byte drain,
//               status/control/end-of-simulation registers and low-watermark irq.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_console #(
    parameter int DEPTH  = 16,
    parameter int GAP    = 0,
    parameter int LOW_WM = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    input  logic [3:0]  we_i,
    input  logic [15:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        end_o,
    output logic [7:0]  exit_code_o,
    output logic        irq_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [CW-1:0] c_depth   = CW'(DEPTH);
    localparam logic [CW-1:0] c_low_wm  = CW'(LOW_WM);
    localparam logic [GW-1:0] c_gap     = GW'(GAP);
    localparam logic [15:0]   c_a_end   = 16'h0000;
    localparam logic [15:0]   c_a_tx0   = 16'h1000;
    localparam logic [15:0]   c_a_stat  = 16'h2000;
    localparam logic [15:0]   c_a_ctrl  = 16'h3000;
    localparam logic [15:0]   c_a_tx1   = 16'h4000;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [GW-1:0] r_gcnt;
    logic          r_overflow;
    logic          r_ie;
    logic          r_end;
    logic [7:0]    r_exit;
    logic [31:0]   r_data;
    logic          r_irq;

    logic          w_rd;
    logic          w_wr;
    logic          w_empty;
    logic          w_full;
    logic          w_tx_valid;
    logic          w_pop;
    logic          w_push_req;
    logic          w_push;
    logic          w_ovf_clr;
    logic          w_ie_next;
    logic [CW-1:0] w_count_next;
    logic [31:0]   w_status;
    logic [31:0]   w_rdata;
    logic          w_unused;

    assign w_rd       = en_i && (we_i == 4'h0);
    assign w_wr       = en_i && (we_i != 4'h0);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_depth);
    assign w_tx_valid = !w_empty && (r_gcnt == '0);
    assign w_pop      = w_tx_valid && tx_ready_i;
    assign w_push_req = en_i && we_i[0] && ((addr_i == c_a_tx0) || (addr_i == c_a_tx1));
    // A push into a full FIFO is still accepted when the head leaves this cycle.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf_clr  = en_i && we_i[0] && (addr_i == c_a_stat) && data_i[2];
    assign w_ie_next  = (en_i && we_i[0] && (addr_i == c_a_ctrl)) ? data_i[0] : r_ie;
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    assign w_status   = {16'h0000, 8'(r_count), 4'h0, r_end, r_overflow, w_full, w_empty};
    assign w_unused   = ^data_i[31:8];

    always_comb begin
        w_rdata = 32'h0;
        case (addr_i)
            c_a_stat: w_rdata = w_status;
            c_a_ctrl: w_rdata = {31'h0, r_ie};
            default:  w_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= data_i[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_gcnt     <= '0;
            r_overflow <= 1'b0;
            r_ie       <= 1'b0;
            r_end      <= 1'b0;
            r_exit     <= 8'h00;
            r_data     <= 32'h0;
            r_irq      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                r_gcnt <= c_gap;
            end else if (r_gcnt != '0) begin
                r_gcnt <= r_gcnt - 1'b1;
            end
            r_count <= w_count_next;
            if (w_push_req && !w_push) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end
            r_ie <= w_ie_next;
            // First END write wins; later ones leave the exit code untouched.
            if (w_wr && (addr_i == c_a_end) && !r_end) begin
                r_end  <= 1'b1;
                r_exit <= data_i[7:0];
            end
            r_data <= w_rd ? w_rdata : 32'h0;
            r_irq  <= w_ie_next && (w_count_next < c_low_wm);
        end
    end

    assign data_o      = r_data;
    assign tx_valid_o  = w_tx_valid;
    assign tx_data_o   = w_empty ? 8'h00 : r_mem[r_rptr];
    assign end_o       = r_end;
    assign exit_code_o = r_exit;
    assign irq_o       = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_mmio_console.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_console
// Description : Self-checking bench; two instances (GAP=0, GAP=3) share stimulus
//               and are compared against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_console;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_i;
    logic [3:0]  we_i;
    logic [15:0] addr_i;
    logic [31:0] data_i;
    logic        tx_ready_i;
    logic [31:0] d_o   [2];
    logic [7:0]  tx_d  [2];
    logic        tx_v  [2];
    logic        end_s [2];
    logic [7:0]  exit_s[2];
    logic        irq_s [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mmio_console #(.DEPTH(16), .GAP(0), .LOW_WM(2)) u_dut0 (
        .clk(clk), .reset(reset), .en_i(en_i), .we_i(we_i), .addr_i(addr_i),
        .data_i(data_i), .data_o(d_o[0]), .tx_data_o(tx_d[0]), .tx_valid_o(tx_v[0]),
        .tx_ready_i(tx_ready_i), .end_o(end_s[0]), .exit_code_o(exit_s[0]), .irq_o(irq_s[0])
    );

    mmio_console #(.DEPTH(16), .GAP(3), .LOW_WM(2)) u_dut3 (
        .clk(clk), .reset(reset), .en_i(en_i), .we_i(we_i), .addr_i(addr_i),
        .data_i(data_i), .data_o(d_o[1]), .tx_data_o(tx_d[1]), .tx_valid_o(tx_v[1]),
        .tx_ready_i(tx_ready_i), .end_o(end_s[1]), .exit_code_o(exit_s[1]), .irq_o(irq_s[1])
    );

    // Reference model state
    logic [7:0] mq0[$];
    logic [7:0] mq1[$];
    int         last_pop[2];
    int         gap_of[2];
    bit         m_ovf[2];
    bit         m_ie;
    bit         m_end;
    logic [7:0] m_exit;
    int         cyc;
    logic [31:0] exp_do[2];
    bit          exp_irq[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic logic [7:0] qhead(input int k);
        if (qsize(k) == 0) return 8'h00;
        return (k == 0) ? mq0[0] : mq1[0];
    endfunction

    function automatic bit m_valid(input int k);
        return (qsize(k) > 0) && (cyc - last_pop[k] > gap_of[k]);
    endfunction

    // One bus cycle: drive, predict, clock, then compare all outputs of both instances.
    task automatic drive(input bit en, input logic [3:0] we, input logic [15:0] addr,
                         input logic [31:0] data, input bit rdy, input bit rst);
        bit rd, wr, preq, ie_next;
        bit pop[2];
        bit push[2];
        int sz;
        en_i = en; we_i = we; addr_i = addr; data_i = data; tx_ready_i = rdy; reset = rst;
        rd = en && (we == 4'h0);
        wr = en && (we != 4'h0);
        preq = en && we[0] && ((addr == 16'h1000) || (addr == 16'h4000));
        ie_next = (en && we[0] && addr == 16'h3000) ? data[0] : m_ie;
        for (int k = 0; k < 2; k++) begin
            sz = qsize(k);
            pop[k]  = m_valid(k) && rdy;
            push[k] = preq && ((sz < 16) || pop[k]);
            exp_do[k] = 32'h0;
            if (rd && addr == 16'h2000)
                exp_do[k] = {16'h0, 8'(sz), 4'h0, m_end, m_ovf[k], sz == 16, sz == 0};
            else if (rd && addr == 16'h3000)
                exp_do[k] = {31'h0, m_ie};
            exp_irq[k] = ie_next && ((sz + int'(push[k]) - int'(pop[k])) < 2);
        end
        @(posedge clk);
        if (rst) begin
            mq0.delete(); mq1.delete();
            for (int k = 0; k < 2; k++) begin
                last_pop[k] = -100; m_ovf[k] = 1'b0; exp_do[k] = 32'h0; exp_irq[k] = 1'b0;
            end
            m_ie = 1'b0; m_end = 1'b0; m_exit = 8'h00;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (pop[k]) begin
                    if (k == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
                    last_pop[k] = cyc;
                end
                if (push[k]) begin
                    if (k == 0) mq0.push_back(data[7:0]); else mq1.push_back(data[7:0]);
                end
                if (preq && !push[k]) m_ovf[k] = 1'b1;
                else if (en && we[0] && addr == 16'h2000 && data[2]) m_ovf[k] = 1'b0;
            end
            m_ie = ie_next;
            if (wr && addr == 16'h0000 && !m_end) begin
                m_end = 1'b1; m_exit = data[7:0];
            end
        end
        cyc++;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("data_o[%0d]", k), d_o[k], exp_do[k]);
            check($sformatf("tx_valid[%0d]", k), 32'(tx_v[k]), 32'(m_valid(k)));
            check($sformatf("tx_data[%0d]", k), 32'(tx_d[k]), 32'(qhead(k)));
            check($sformatf("irq[%0d]", k), 32'(irq_s[k]), 32'(exp_irq[k]));
            check($sformatf("end[%0d]", k), 32'(end_s[k]), 32'(m_end));
            check($sformatf("exit[%0d]", k), 32'(exit_s[k]), 32'(m_exit));
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 16'h0, 32'h0, rdy, 1'b0);
    endtask

    initial begin
        logic [15:0] a;
        logic [3:0]  w;
        gap_of[0] = 0; gap_of[1] = 3;
        last_pop[0] = -100; last_pop[1] = -100;
        m_ovf[0] = 0; m_ovf[1] = 0; m_ie = 0; m_end = 0; m_exit = 0; cyc = 0;
        @(negedge clk);
        drive(1'b0, 4'h0, 16'h0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 4'h0, 16'h0, 32'h0, 1'b0, 1'b1);

        // Single byte
        drive(1'b1, 4'h1, 16'h4000, 32'h41, 1'b1, 1'b0);
        check("single_valid", 32'(tx_v[0]), 32'h1);
        check("single_data", 32'(tx_d[0]), 32'h41);
        idle(1, 1'b1);
        drive(1'b1, 4'h0, 16'h2000, 32'h0, 1'b1, 1'b0);
        check("single_status", d_o[0], 32'h0000_0001);
        idle(8, 1'b1);

        // Overflow
        for (int i = 0; i < 17; i++) drive(1'b1, 4'h1, 16'h1000, 32'(i), 1'b0, 1'b0);
        drive(1'b1, 4'h0, 16'h2000, 32'h0, 1'b0, 1'b0);
        check("ovf_status0", d_o[0], 32'h0000_1006);
        check("ovf_status3", d_o[1], 32'h0000_1006);
        idle(70, 1'b1);
        drive(1'b1, 4'h1, 16'h2000, 32'h4, 1'b1, 1'b0);
        drive(1'b1, 4'h0, 16'h2000, 32'h0, 1'b1, 1'b0);
        check("ovf_cleared", d_o[0], 32'h0000_0001);

        // Push and pop on full
        for (int i = 0; i < 16; i++) drive(1'b1, 4'h1, 16'h4000, 32'(8'h60 + i), 1'b0, 1'b0);
        drive(1'b1, 4'h1, 16'h4000, 32'hAA, 1'b1, 1'b0);
        drive(1'b1, 4'h0, 16'h2000, 32'h0, 1'b0, 1'b0);
        check("fullpp_status", d_o[0], 32'h0000_1002);
        idle(70, 1'b1);

        // Pacing with a ready drop
        for (int i = 0; i < 4; i++) drive(1'b1, 4'h1, 16'h4000, 32'(8'hB0 + i), 1'b1, 1'b0);
        idle(2, 1'b0);
        idle(20, 1'b1);

        // Interrupt
        drive(1'b1, 4'h1, 16'h3000, 32'h1, 1'b0, 1'b0);
        check("irq_on", 32'(irq_s[0]), 32'h1);
        drive(1'b1, 4'h1, 16'h4000, 32'h11, 1'b0, 1'b0);
        drive(1'b1, 4'h1, 16'h4000, 32'h12, 1'b0, 1'b0);
        check("irq_fall", 32'(irq_s[0]), 32'h0);
        idle(1, 1'b1);
        check("irq_rise", 32'(irq_s[0]), 32'h1);
        idle(10, 1'b1);

        // End and reset
        drive(1'b1, 4'hF, 16'h0000, 32'h05, 1'b1, 1'b0);
        drive(1'b1, 4'h1, 16'h0000, 32'h07, 1'b1, 1'b0);
        check("end_flag", 32'(end_s[0]), 32'h1);
        check("exit_code", 32'(exit_s[0]), 32'h05);
        for (int i = 0; i < 3; i++) drive(1'b1, 4'h1, 16'h4000, 32'(8'hC0 + i), 1'b0, 1'b0);
        drive(1'b0, 4'h0, 16'h0, 32'h0, 1'b1, 1'b1);
        check("rst_valid", 32'(tx_v[0]), 32'h0);
        check("rst_end", 32'(end_s[0]), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: a = 16'h4000;
                3:       a = 16'h1000;
                4, 5:    a = 16'h2000;
                6:       a = 16'h3000;
                7:       a = 16'h0000;
                8:       a = 16'($urandom);
                default: a = 16'h2004;
            endcase
            case ($urandom_range(0, 4))
                0, 1:    w = 4'h0;
                2:       w = 4'h1;
                3:       w = 4'h2;
                default: w = 4'($urandom);
            endcase
            drive($urandom_range(0, 2) != 0, w, a, $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 299) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
